// File: rtl/key_control.sv
// key_control: debounced push-button with short/long press classification
// driving LED on/flash toggles.
module key_control #(
  parameter logic [15:0] DEBOUNCE_TICKS = 16'd20,
  parameter logic [15:0] LONG_TICKS     = 16'd1000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_divider,
  input  logic       i_key,
  output logic       o_key_level,
  output logic       o_short_press,
  output logic       o_long_press,
  output logic       o_led_on,
  output logic       o_led_flash
);
  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] PRESSED   = 2'd1;
  localparam logic [1:0] LONG_HELD = 2'd2;
  logic        key_meta;
  logic        key_sync;
  logic [7:0]  pre_cnt;
  logic        tick;
  logic [15:0] deb_cnt;
  logic [15:0] hold_cnt;
  logic [1:0]  state;
  // >= rather than == so a lowered divider wraps on the next clock
  assign tick = pre_cnt >= i_divider;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      key_meta <= 1'b0;
      key_sync <= 1'b0;
      pre_cnt  <= '0;
    end else begin
      key_meta <= ~i_key;
      key_sync <= key_meta;
      pre_cnt  <= tick ? '0 : pre_cnt + 8'd1;
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      deb_cnt     <= '0;
      o_key_level <= 1'b0;
    end else if (key_sync == o_key_level) begin
      deb_cnt <= '0;
    end else if (tick) begin
      if (deb_cnt == DEBOUNCE_TICKS - 16'd1) begin
        o_key_level <= key_sync;
        deb_cnt     <= '0;
      end else begin
        deb_cnt <= deb_cnt + 16'd1;
      end
    end
  end
  // long threshold is tested before release so a coincident release yields only the long pulse
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      hold_cnt      <= '0;
      o_short_press <= 1'b0;
      o_long_press  <= 1'b0;
      o_led_on      <= 1'b0;
      o_led_flash   <= 1'b0;
    end else begin
      o_short_press <= 1'b0;
      o_long_press  <= 1'b0;
      case (state)
        IDLE: if (o_key_level) begin
          state    <= PRESSED;
          hold_cnt <= '0;
        end
        PRESSED: if (tick && hold_cnt == LONG_TICKS - 16'd1) begin
          state        <= LONG_HELD;
          o_long_press <= 1'b1;
          o_led_flash  <= ~o_led_flash;
        end else if (!o_key_level) begin
          state         <= IDLE;
          o_short_press <= 1'b1;
          o_led_on      <= ~o_led_on;
        end else if (tick) begin
          hold_cnt <= hold_cnt + 16'd1;
        end
        LONG_HELD: if (!o_key_level) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_key_control.sv
// tb_key_control: directed checks of debounce timing, press classification,
// LED toggles and reset behaviour with DEBOUNCE_TICKS=4, LONG_TICKS=10.
module tb_key_control;
  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic [7:0] i_divider;
  logic       i_key;
  logic       o_key_level;
  logic       o_short_press;
  logic       o_long_press;
  logic       o_led_on;
  logic       o_led_flash;
  int vectors = 0;
  int errs = 0;
  int sc = 0, lc = 0, both = 0, lvl = 0;
  int s0, l0, v0, n, m;

  key_control #(.DEBOUNCE_TICKS(16'd4), .LONG_TICKS(16'd10)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_divider(i_divider), .i_key(i_key),
    .o_key_level(o_key_level), .o_short_press(o_short_press),
    .o_long_press(o_long_press), .o_led_on(o_led_on), .o_led_flash(o_led_flash)
  );

  always #5 i_clk = ~i_clk;

  // pulse counters sampled mid-cycle; a pulse wider than one clock counts twice
  always @(negedge i_clk) begin
    if (o_short_press) sc++;
    if (o_long_press) lc++;
    if (o_short_press && o_long_press) both++;
    if (o_key_level) lvl++;
  end

  task automatic step(input int k);
    repeat (k) @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    i_rst_n = 1'b0; i_key = 1'b1; i_divider = 8'd0;
    step(3);
    check("rst_level", o_key_level, 0);
    check("rst_short", o_short_press, 0);
    check("rst_long", o_long_press, 0);
    check("rst_led_on", o_led_on, 0);
    check("rst_flash", o_led_flash, 0);
    @(negedge i_clk) i_rst_n = 1'b1;
    step(5);
    // long press: level rises at edge 6, long pulse at edge 17
    s0 = sc; l0 = lc;
    @(negedge i_clk) i_key = 1'b0;
    step(5);  check("long_lvl_e5", o_key_level, 0);
    step(1);  check("long_lvl_e6", o_key_level, 1);
    step(10); check("long_pulse_e16", o_long_press, 0);
    step(1);  check("long_pulse_e17", o_long_press, 1);
    check("long_flash", o_led_flash, 1);
    step(1);  check("long_pulse_e18", o_long_press, 0);
    repeat (12) @(posedge i_clk);
    @(negedge i_clk) i_key = 1'b1;
    step(20);
    check("long_nshort", sc - s0, 0);
    check("long_nlong", lc - l0, 1);
    check("long_lvl_end", o_key_level, 0);
    // two 8-clock presses: short pulse at edge 15, LED toggles on then off
    for (int k = 0; k < 2; k++) begin
      @(negedge i_clk) i_key = 1'b0;
      repeat (8) @(negedge i_clk);
      i_key = 1'b1;
      step(5); check("short_lvl_e13", o_key_level, 1);
      step(1); check("short_lvl_e14", o_key_level, 0);
      check("short_pulse_e14", o_short_press, 0);
      step(1); check("short_pulse_e15", o_short_press, 1);
      check("short_led_on", o_led_on, (k == 0) ? 1 : 0);
      check("short_nolong", o_long_press, 0);
      step(1); check("short_pulse_e16", o_short_press, 0);
      step(10);
    end
    // glitches of 3 clocks never reach the debounce threshold
    s0 = sc; l0 = lc; v0 = lvl;
    @(negedge i_clk);
    for (int k = 0; k < 10; k++) begin
      i_key = 1'b0;
      repeat (3) @(negedge i_clk);
      i_key = 1'b1;
      repeat (3) @(negedge i_clk);
    end
    step(10);
    check("glitch_lvl", lvl - v0, 0);
    check("glitch_pulses", (sc - s0) + (lc - l0), 0);
    // prescaled: divider 3
    @(negedge i_clk) i_divider = 8'd3;
    step(8);
    s0 = sc; l0 = lc;
    @(negedge i_clk) i_key = 1'b0;
    n = 0;
    while (!o_key_level && n < 40) begin step(1); n++; end
    check("div_rise_window", (n >= 15 && n <= 21), 1);
    m = 0;
    while (!o_long_press && m < 60) begin step(1); m++; end
    check("div_long_window", (m >= 37 && m <= 43), 1);
    check("div_flash", o_led_flash, 0);
    @(negedge i_clk) i_key = 1'b1;
    step(40);
    check("div_lvl_end", o_key_level, 0);
    check("div_nshort", sc - s0, 0);
    check("div_nlong", lc - l0, 1);
    @(negedge i_clk) i_divider = 8'd0;
    step(5);
    // reset mid-press, key released during reset: press discarded
    s0 = sc; l0 = lc;
    @(negedge i_clk) i_key = 1'b0;
    step(10);
    check("rstp_lvl_before", o_key_level, 1);
    @(negedge i_clk) begin i_rst_n = 1'b0; i_key = 1'b1; end
    #1 check("rstp_lvl_async", o_key_level, 0);
    step(2);
    @(negedge i_clk) i_rst_n = 1'b1;
    step(20);
    check("rstp_pulses", (sc - s0) + (lc - l0), 0);
    check("rstp_led_on", o_led_on, 0);
    check("rstp_flash", o_led_flash, 0);
    // reset with key still held: re-debounced as a fresh press
    @(negedge i_clk) i_key = 1'b0;
    step(10);
    @(negedge i_clk) i_rst_n = 1'b0;
    step(2);
    @(negedge i_clk) i_rst_n = 1'b1;
    n = 0;
    while (!o_key_level && n < 20) begin step(1); n++; end
    check("rsth_rise", n, 6);
    @(negedge i_clk) i_key = 1'b1;
    m = 0;
    while (!o_short_press && m < 30) begin step(1); m++; end
    check("rsth_short", o_short_press, 1);
    check("rsth_led_on", o_led_on, 1);
    step(10);
    // release coinciding with long threshold: long wins
    s0 = sc; l0 = lc;
    @(negedge i_clk) i_key = 1'b0;
    repeat (10) @(negedge i_clk);
    i_key = 1'b1;
    step(6); check("tie_lvl_e16", o_key_level, 0);
    check("tie_long_e16", o_long_press, 0);
    step(1); check("tie_long_e17", o_long_press, 1);
    check("tie_short_e17", o_short_press, 0);
    check("tie_flash", o_led_flash, 1);
    step(1); check("tie_long_e18", o_long_press, 0);
    step(10);
    check("tie_nshort", sc - s0, 0);
    check("tie_nlong", lc - l0, 1);
    check("tie_led_on", o_led_on, 1);
    check("never_both", both, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/key_control.md
KEY_CONTROL -- requirements
Module: key_control

Interface
REQ-001 Parameter DEBOUNCE_TICKS, 16'd20, consecutive ticks a changed key level must persist before acceptance (legal 1..65535).
REQ-002 Parameter LONG_TICKS, 16'd1000, ticks a press must be held to classify as long (legal 1..65535).
REQ-003 i_clk  input  1  single clock; all logic on its rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 i_divider  input  8  tick prescaler; one tick every i_divider+1 clocks.
REQ-006 i_key  input  1  raw push-button, active-low (0 = pressed), asynchronous to i_clk.
REQ-007 o_key_level  output  1  debounced key state, 1 = pressed.
REQ-008 o_short_press  output  1  one-clock pulse on release of a press shorter than LONG_TICKS.
REQ-009 o_long_press  output  1  one-clock pulse when a press reaches LONG_TICKS.
REQ-010 o_led_on  output  1  toggled by each short press; drives the LED driver on input.
REQ-011 o_led_flash  output  1  toggled by each long press; drives the LED driver flash input.

Function
REQ-012 i_key SHALL pass a 2-flop synchronizer; only the second flop (key_sync, inverted to active-high) feeds logic.
REQ-013 Prescaler: 8-bit counter; when count >= i_divider, tick=1 for that clock and count <= 0, else count+1; i_divider=0 gives tick every clock; a lowered i_divider takes effect without exceeding one extra wrap.
REQ-014 Debounce: 16-bit counter clears on any clock where key_sync == o_key_level; on a tick with mismatch it increments; when mismatch persists and counter == DEBOUNCE_TICKS-1 on a tick, o_key_level <= key_sync and counter <= 0.
REQ-015 With i_divider=0, o_key_level SHALL change exactly DEBOUNCE_TICKS+2 clocks after a clean i_key edge; a glitch shorter than DEBOUNCE_TICKS ticks SHALL never change o_key_level.
REQ-016 FSM states IDLE, PRESSED, LONG_HELD; reset state IDLE.
REQ-017 IDLE: o_key_level==1 -> PRESSED, hold counter <= 0.
REQ-018 PRESSED: each tick hold counter +1; when hold counter reaches LONG_TICKS-1 on a tick -> LONG_HELD, o_long_press=1 next clock, o_led_flash toggles same clock as pulse.
REQ-019 PRESSED: o_key_level==0 -> IDLE, o_short_press=1 next clock, o_led_on toggles same clock as pulse.
REQ-020 If release and long threshold coincide in the same clock, long SHALL win (o_long_press only, then IDLE next clock, no short pulse).
REQ-021 LONG_HELD: o_key_level==0 -> IDLE, no pulse; hold counter frozen (no wrap).
REQ-022 o_short_press and o_long_press SHALL be registered, never both 1, each exactly one clock wide.
REQ-023 Presses are serialized: a new press is only recognised from IDLE; back-to-back presses each produce their own pulse.

Reset
REQ-024 On i_rst_n=0 all state clears immediately: synchronizer flops to 0 (not pressed), prescaler, debounce and hold counters 0, FSM IDLE, all outputs 0.
REQ-025 Reset mid-press SHALL discard the press: no pulse after release; a still-held key after reset is re-debounced and classified as a fresh press.
REQ-026 Reset deassertion needs no synchronisation beyond the team's standard reset synchronizer upstream.

Verification (DEBOUNCE_TICKS=4, LONG_TICKS=10, i_divider=0 unless stated)
REQ-027 i_key 1->0 held 30 clocks then 1 -> o_key_level rises 6 clocks after fall; o_long_press pulse 1 clock; o_led_flash 0->1; no o_short_press.
REQ-028 i_key low 8 clocks then high -> o_short_press one pulse after o_key_level falls; o_led_on 0->1; second identical press returns o_led_on to 0.
REQ-029 i_key low pulses of 3 clocks separated by 3 clocks high, repeated 10x -> o_key_level stays 0, no pulses.
REQ-030 i_divider=3, i_key low held -> o_key_level rises 2+4*4 clocks (+/- prescaler phase, max 3) after fall; long pulse after 40 further clocks (+/-3).
REQ-031 i_rst_n pulsed low while in PRESSED, key released after reset -> all outputs 0, no pulse, o_led_on/o_led_flash unchanged at 0.
REQ-032 Release timed so debounced fall coincides with hold counter reaching 9 -> only o_long_press asserted.
